// File: rtl/sel_ctrl_pkg.sv
// Shared definitions for the debug display selector controller.
// Holds the source index encoding, display geometry constants, the
// internal step-request type and a helper that locates the most
// significant non-zero hex digit of a 32-bit word.
package sel_ctrl_pkg;

  localparam int SEL_W       = 3;
  localparam int NIB_W       = 4;
  localparam int NUM_DIG     = 8;
  localparam int DIG_IDX_W   = $clog2(NUM_DIG);
  localparam int NUM_SRC_DEF = 5;

  // Source indices as seen by the selector mux
  typedef enum logic [SEL_W-1:0] {
    SRC_RDATA1 = 3'd0,
    SRC_RDATA2 = 3'd1,
    SRC_RESULT = 3'd2,
    SRC_WDATA  = 3'd3,
    SRC_NEXTPC = 3'd4
  } src_e;

  // Resolved request for one cycle of source stepping
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_NEXT = 2'd1,
    STEP_PREV = 2'd2
  } step_e;

  // Index of the highest non-zero nibble; 0 when the whole word is zero,
  // so digit 0 always counts as significant.
  function automatic logic [DIG_IDX_W-1:0] msNibble(input logic [NUM_DIG*NIB_W-1:0] value);
    logic [DIG_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 1; i < NUM_DIG; i++) begin
      if (value[i*NIB_W +: NIB_W] != '0) begin
        idx = DIG_IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sel_scan_ctrl_btn_debounce.sv
// btn_debounce: conditions one raw push-button.
// A 2-flop synchroniser feeds a counter that must see the synchronised
// level disagree with the accepted level for DEB_CYCLES consecutive
// cycles before the new level is accepted. A one-cycle pulse is emitted
// when the accepted level goes 0->1; releases produce nothing.
// Ports:
//   clk_i   - system clock
//   rst_i   - asynchronous reset, active-high
//   btn_i   - raw button level
//   pulse_o - one-cycle press pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level, so any bounce back to the old level restarts it.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q[1];
        pulse_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/sel_scan_ctrl.sv
// sel_scan_ctrl: debug display selector controller for the MIPS board.
// Steps the 3-bit source select from two debounced buttons or rotates it
// automatically, and scans the selected 32-bit value onto an 8-digit
// common-anode seven-segment display, one hex nibble per digit.
// Optional build macro: BLANK_LEAD_EN - blank digits above the most
// significant non-zero nibble (digit 0 always lit).
// Ports:
//   CLK      - system clock
//   RST      - asynchronous reset, active-high
//   BTN_NEXT - raw button, step source forward
//   BTN_PREV - raw button, step source back
//   AUTO_EN  - slide switch, 1 = auto-rotate
//   VDATA    - value of the currently selected source
//   SEL      - source select to the selector
//   DIG_AN   - digit enables, active-low
//   DIG_NIB  - hex nibble for the active digit
module sel_scan_ctrl
  import sel_ctrl_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int DEB_CYCLES = 1000000,
  parameter int AUTO_DIV   = 50000000,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     BTN_NEXT,
  input  logic                     BTN_PREV,
  input  logic                     AUTO_EN,
  input  logic [NUM_DIG*NIB_W-1:0] VDATA,
  output logic [SEL_W-1:0]         SEL,
  output logic [NUM_DIG-1:0]       DIG_AN,
  output logic [NIB_W-1:0]         DIG_NIB
);

  localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0]  SEL_MAX   = SEL_W'(NUM_SRC - 1);

  logic                     nextPulse, prevPulse;
  step_e                    step;
  logic [1:0]               autoSync_q;
  logic                     autoTick;
  logic [AUTO_W-1:0]        autoCnt_q, autoCnt_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [SCAN_W-1:0]        scanCnt_q, scanCnt_d;
  logic [DIG_IDX_W-1:0]     digIdx_q, digIdx_d;
  logic [NUM_DIG-1:0]       digAn_q, digAn_d;
  logic [NIB_W-1:0]         digNib_q, digNib_d;
  logic [NUM_DIG*NIB_W-1:0] snap_q, snap_d;
  logic [NUM_DIG*NIB_W-1:0] frameData;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) uNextDeb (
    .clk_i   (CLK),
    .rst_i   (RST),
    .btn_i   (BTN_NEXT),
    .pulse_o (nextPulse)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) uPrevDeb (
    .clk_i   (CLK),
    .rst_i   (RST),
    .btn_i   (BTN_PREV),
    .pulse_o (prevPulse)
  );

  // Opposing presses landing in the same cycle cancel out.
  always_comb begin
    step = STEP_NONE;
    if (nextPulse && !prevPulse) begin
      step = STEP_NEXT;
    end else if (prevPulse && !nextPulse) begin
      step = STEP_PREV;
    end
  end

  // Any button activity restarts the auto period and takes priority over a
  // coincident auto tick, so a press never yields a double step.
  always_comb begin
    autoTick  = autoSync_q[1] && (autoCnt_q == AUTO_LAST);
    sel_d     = sel_q;
    autoCnt_d = autoCnt_q;
    if (!autoSync_q[1] || nextPulse || prevPulse || autoTick) begin
      autoCnt_d = '0;
    end else begin
      autoCnt_d = autoCnt_q + 1'b1;
    end
    if (step == STEP_PREV) begin
      sel_d = (sel_q == '0 || sel_q > SEL_MAX) ? SEL_MAX : sel_q - 1'b1;
    end else if (step == STEP_NEXT || (autoTick && !nextPulse && !prevPulse)) begin
      sel_d = (sel_q >= SEL_MAX) ? '0 : sel_q + 1'b1;
    end
  end

  // Digit scan. The snapshot is reloaded as digit 0 comes up, and digit 0
  // reads the fresh VDATA directly, so all 8 digits of a frame come from
  // one consistent value.
  always_comb begin
    scanCnt_d = (scanCnt_q == SCAN_LAST) ? '0 : scanCnt_q + 1'b1;
    digIdx_d  = digIdx_q;
    digAn_d   = digAn_q;
    digNib_d  = digNib_q;
    snap_d    = snap_q;
    frameData = snap_q;
    if (scanCnt_q == SCAN_LAST) begin
      digIdx_d = digIdx_q + 1'b1;
      if (digIdx_d == '0) begin
        snap_d    = VDATA;
        frameData = VDATA;
      end
      digNib_d = frameData[{digIdx_d, 2'b00} +: NIB_W];
      digAn_d  = ~(NUM_DIG'(1) << digIdx_d);
`ifdef BLANK_LEAD_EN
      if (digIdx_d > msNibble(frameData)) begin
        digAn_d = '1;
      end
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      autoSync_q <= '0;
      autoCnt_q  <= '0;
      sel_q      <= SRC_RDATA1;
      scanCnt_q  <= '0;
      digIdx_q   <= '0;
      digAn_q    <= ~NUM_DIG'(1);
      digNib_q   <= '0;
      snap_q     <= '0;
    end else begin
      autoSync_q <= {autoSync_q[0], AUTO_EN};
      autoCnt_q  <= autoCnt_d;
      sel_q      <= sel_d;
      scanCnt_q  <= scanCnt_d;
      digIdx_q   <= digIdx_d;
      digAn_q    <= digAn_d;
      digNib_q   <= digNib_d;
      snap_q     <= snap_d;
    end
  end

  assign SEL     = sel_q;
  assign DIG_AN  = digAn_q;
  assign DIG_NIB = digNib_q;

endmodule

// File: tb/tb_sel_scan_ctrl.sv
// Testbench for sel_scan_ctrl with short debounce, auto and scan periods.
// Source-select expectations come from modular arithmetic on the presses
// made; display expectations come from the value latched at each frame start.
module tb_sel_scan_ctrl;

  localparam int NSRC = 5;
  localparam int DEB  = 4;
  localparam int AUTO = 10;
  localparam int SCAN = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        btnNext, btnPrev, autoEn;
  logic [31:0] vdata;
  logic [2:0]  sel;
  logic [7:0]  digAn;
  logic [3:0]  digNib;

  int checks   = 0;
  int failures = 0;
  int selModel = 0;

  sel_scan_ctrl #(
    .NUM_SRC    (NSRC),
    .DEB_CYCLES (DEB),
    .AUTO_DIV   (AUTO),
    .SCAN_DIV   (SCAN)
  ) dut (
    .CLK      (clock),
    .RST      (reset),
    .BTN_NEXT (btnNext),
    .BTN_PREV (btnPrev),
    .AUTO_EN  (autoEn),
    .VDATA    (vdata),
    .SEL      (sel),
    .DIG_AN   (digAn),
    .DIG_NIB  (digNib)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Expected anode pattern for digit d of a frame showing data
  function automatic logic [7:0] expAn(input int d, input logic [31:0] data);
`ifdef BLANK_LEAD_EN
    int msd;
    msd = 0;
    for (int i = 1; i < 8; i++) begin
      if (data[4*i +: 4] != 4'h0) msd = i;
    end
    if (d > msd) return 8'hFF;
`endif
    return ~(8'h01 << d);
  endfunction

  // One button press (optionally bouncing first), held, then released
  task automatic applyStimulus(input bit doNext, input bit doPrev, input bit bounce);
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        btnNext = doNext && (i % 2 == 0);
        btnPrev = doPrev && (i % 2 == 0);
        repeat (2) @(negedge clock);
      end
    end
    btnNext = doNext;
    btnPrev = doPrev;
    repeat (10) @(negedge clock);
    if (doNext && !doPrev) selModel = (selModel + 1) % NSRC;
    else if (doPrev && !doNext) selModel = (selModel + NSRC - 1) % NSRC;
    checkOutput("selPress", sel, selModel);
    btnNext = 1'b0;
    btnPrev = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("selRelease", sel, selModel);
  endtask

  task automatic waitSelChange(input int limit, output int cyc);
    logic [2:0] prev;
    prev = sel;
    cyc  = 0;
    while (sel == prev && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= limit) checkOutput("selChangeTimeout", sel, (prev + 1) % NSRC);
  endtask

  // Checks frames slot by slot; optional fixed change of VDATA in the first
  // frame and optional random mid-frame changes in every frame.
  task automatic runScan(input int frames, input int changeSlot, input logic [31:0] changeVal,
                         input bit randomChanges);
    logic [31:0] frameData;
    int guard, d, rslot;
    guard = 0;
    rslot = -1;
    frameData = vdata;
    while (digAn == 8'hFE && guard < 40) begin @(negedge clock); guard++; end
    while (digAn != 8'hFE && guard < 40) begin @(negedge clock); guard++; end
    if (guard >= 40) checkOutput("scanAlignTimeout", digAn, 8'hFE);
    for (int s = 0; s < frames * 8; s++) begin
      d = s % 8;
      if (d == 0) begin
        frameData = vdata;
        rslot = randomChanges ? int'($urandom_range(0, 7)) : -1;
      end
      checkOutput($sformatf("scanAn%0d", d), digAn, expAn(d, frameData));
      checkOutput($sformatf("scanNib%0d", d), digNib, frameData[4*d +: 4]);
      if (s == changeSlot) vdata = changeVal;
      if (d == rslot) vdata = $urandom >> $urandom_range(0, 31);
      repeat (SCAN) @(negedge clock);
    end
  endtask

  initial begin
    int kind, cyc, changes, firstAt, secondAt;
    logic [2:0] prevSel;

    reset   = 1'b1;
    btnNext = 1'b0;
    btnPrev = 1'b0;
    autoEn  = 1'b0;
    vdata   = 32'h0;
    repeat (3) @(negedge clock);
    checkOutput("rstSel", sel, 0);
    checkOutput("rstAn", digAn, 8'hFE);
    checkOutput("rstNib", digNib, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Bouncing press gives one step; then wrap both ways
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 2);
      applyStimulus(kind != 1, kind != 0, 1'($urandom_range(0, 1)));
    end

    // Auto rotation
    autoEn = 1'b1;
    waitSelChange(40, cyc);
    selModel = (selModel + 1) % NSRC;
    checkOutput("autoStep0", sel, selModel);
    for (int i = 1; i <= 2; i++) begin
      waitSelChange(AUTO + 5, cyc);
      selModel = (selModel + 1) % NSRC;
      checkOutput($sformatf("autoPeriod%0d", i), cyc, AUTO);
      checkOutput($sformatf("autoStep%0d", i), sel, selModel);
    end

    // Button press shortly after an auto step restarts the period
    changes  = 0;
    firstAt  = 0;
    secondAt = 0;
    prevSel  = sel;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clock);
      if (c == 1) btnNext = 1'b1;
      if (c == 14) btnNext = 1'b0;
      if (sel != prevSel) begin
        changes++;
        if (changes == 1) firstAt = c;
        else if (changes == 2) secondAt = c;
        prevSel = sel;
      end
    end
    autoEn = 1'b0;
    selModel = (selModel + 2) % NSRC;
    checkOutput("autoBtnChanges", changes, 2);
    checkOutput("autoBtnBeforeTick", (firstAt > 0 && firstAt < AUTO) ? 1 : 0, 1);
    checkOutput("autoAfterBtn", secondAt - firstAt, AUTO);
    checkOutput("autoBtnSel", sel, selModel);
    repeat (30) @(negedge clock);
    checkOutput("autoOffHold", sel, selModel);

    // Display scan, mid-frame change, leading-zero value, random frames
    vdata = 32'h1234ABCD;
    runScan(2, 3, 32'h0, 1'b0);
    vdata = 32'h000000A5;
    runScan(1, -1, 32'h0, 1'b0);
    vdata = 32'h0;
    runScan(1, -1, 32'h0, 1'b0);
    vdata = $urandom;
    runScan(6, -1, 32'h0, 1'b1);

    // Asynchronous reset mid-count with SEL at 3
    vdata = 32'h1234ABCD;
    while (selModel != 3) applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstSel", sel, 0);
    checkOutput("asyncRstAn", digAn, 8'hFE);
    checkOutput("asyncRstNib", digNib, 0);
    selModel = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    while (digAn == 8'hFE && cyc < 10) begin @(negedge clock); cyc++; end
    checkOutput("firstTickAn", digAn, 8'hFD);
    checkOutput("firstTickNib", digNib, 0);
    checkOutput("postRstSel", sel, selModel);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
